// File: rtl/qei_encoder_gen.sv
// Quadrature encoder emulator: turns signed move commands (edge count + edge period)
// into registered A/B quadrature, a once-per-revolution index and a position count.
module qei_encoder_gen #(
    parameter int CPR     = 4000,
    parameter int PER_W   = 16,
    parameter int DELTA_W = 16,
    parameter int POS_W   = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DELTA_W-1:0] cmd_delta,
    input  logic [PER_W-1:0]   cmd_period,
    input  logic               abort,
    output logic               qei_a,
    output logic               qei_b,
    output logic               qei_i,
    output logic [POS_W-1:0]   position,
    output logic               busy,
    output logic               done
);

    localparam int ANG_W = (CPR > 2) ? $clog2(CPR) : 1;
    localparam logic [ANG_W-1:0] ANG_MAX = ANG_W'(CPR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [ANG_W-1:0]   ang_q, ang_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [PER_W-1:0]   timer_q, timer_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [DELTA_W:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               qei_a_q, qei_a_d;
    logic               qei_b_q, qei_b_d;
    logic               qei_i_q, qei_i_d;

    logic [DELTA_W:0]   delta_ext;
    logic [DELTA_W:0]   delta_mag;
    logic [PER_W-1:0]   per_sel;

    // One extra bit so the magnitude of the most negative command is representable.
    assign delta_ext = {cmd_delta[DELTA_W-1], cmd_delta};
    assign delta_mag = cmd_delta[DELTA_W-1] ? (~delta_ext + 1'b1) : delta_ext;
    assign per_sel   = (cmd_period == '0) ? PER_W'(1) : cmd_period;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        ang_d     = ang_q;
        pos_d     = pos_q;
        timer_d   = timer_q;
        per_d     = per_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = !abort;
                if (cmd_valid && !abort) begin
                    if (cmd_delta == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d   = cmd_delta[DELTA_W-1];
                        rem_d   = delta_mag;
                        per_d   = per_sel;
                        timer_d = per_sel - 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    timer_d = '0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    if (dir_q) begin
                        ang_d = (ang_q == '0) ? ANG_MAX : ang_q - 1'b1;
                        pos_d = pos_q - 1'b1;
                    end else begin
                        ang_d = (ang_q == ANG_MAX) ? '0 : ang_q + 1'b1;
                        pos_d = pos_q + 1'b1;
                    end
                    rem_d   = rem_q - 1'b1;
                    timer_d = per_q - 1'b1;
                    if (rem_q == {{DELTA_W{1'b0}}, 1'b1}) begin
                        done_d  = 1'b1;
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next angle so an edge is visible in the same cycle the angle steps.
    always_comb begin
        qei_a_d = ang_d[0] ^ ang_d[ANG_W-1 > 0 ? 1 : 0];
        qei_b_d = ang_d[ANG_W-1 > 0 ? 1 : 0];
        qei_i_d = (ang_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop has a reset value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            ang_q   <= '0;
            pos_q   <= '0;
            timer_q <= '0;
            per_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            qei_a_q <= 1'b0;
            qei_b_q <= 1'b0;
            qei_i_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ang_q   <= ang_d;
            pos_q   <= pos_d;
            timer_q <= timer_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            qei_a_q <= qei_a_d;
            qei_b_q <= qei_b_d;
            qei_i_q <= qei_i_d;
        end
    end

    assign qei_a    = qei_a_q;
    assign qei_b    = qei_b_q;
    assign qei_i    = qei_i_q;
    assign position = pos_q;
    assign done     = done_q;
    assign busy     = (state_q == RUN);

endmodule
